// File: rtl/spi_burst_sequencer_if.sv
// Bus bundle for spi_burst_sequencer: control/status, buffer RAM port and SPI engine handshake.
//
// Signal summary
//   Control in  : Go, Abort, Mode[1:0], Length[LEN_WIDTH-1:0], KeepCSAfter
//   Status out  : Busy, Done, TokenTimeout, Aborted
//   Buffer RAM  : BufAddr (out), BufRdData (in, 1-cycle latency), BufWrData (out), BufWe (out)
//   SPI engine  : SpiDataOut, SpiStart, SpiKeepCS (out); SpiBusy, SpiDataIn (in)
//
// Modport master is the sequencer side; modport slave is the surrounding system.
interface spi_burst_sequencer_if #(
    parameter int unsigned LEN_WIDTH = 9
);
    logic                 Go;
    logic                 Abort;
    logic [1:0]           Mode;
    logic [LEN_WIDTH-1:0] Length;
    logic                 KeepCSAfter;
    logic                 Busy;
    logic                 Done;
    logic                 TokenTimeout;
    logic                 Aborted;
    logic [LEN_WIDTH-1:0] BufAddr;
    logic [7:0]           BufRdData;
    logic [7:0]           BufWrData;
    logic                 BufWe;
    logic [7:0]           SpiDataOut;
    logic                 SpiStart;
    logic                 SpiKeepCS;
    logic                 SpiBusy;
    logic [7:0]           SpiDataIn;

    modport master (
        input  Go, Abort, Mode, Length, KeepCSAfter, BufRdData, SpiBusy, SpiDataIn,
        output Busy, Done, TokenTimeout, Aborted, BufAddr, BufWrData, BufWe,
               SpiDataOut, SpiStart, SpiKeepCS
    );

    modport slave (
        output Go, Abort, Mode, Length, KeepCSAfter, BufRdData, SpiBusy, SpiDataIn,
        input  Busy, Done, TokenTimeout, Aborted, BufAddr, BufWrData, BufWe,
               SpiDataOut, SpiStart, SpiKeepCS
    );
endinterface

// File: rtl/spi_burst_sequencer.sv
// Burst sequencer in front of the SPI byte engine. Streams bytes from a buffer RAM into the
// engine and stores received bytes back, with optional SD-style start-token polling.
//
// Ports
//   FastClk : clock
//   Reset   : synchronous active-high reset
//   bus     : spi_burst_sequencer_if.master (control/status, buffer RAM, engine handshake)
//
// Modes: 00 TX, 01 RX, 10 exchange, 11 RX after start token.
module spi_burst_sequencer #(
    parameter int unsigned LEN_WIDTH   = 9,
    parameter int unsigned TOKEN_LIMIT = 1023
) (
    input logic                          FastClk,
    input logic                          Reset,
    spi_burst_sequencer_if.master        bus
);
    localparam int unsigned PollW = $clog2(TOKEN_LIMIT + 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StFetch  = 3'd1;
    localparam logic [2:0] StLoad   = 3'd2;
    localparam logic [2:0] StStart  = 3'd3;
    localparam logic [2:0] StAck    = 3'd4;
    localparam logic [2:0] StXfer   = 3'd5;
    localparam logic [2:0] StStore  = 3'd6;
    localparam logic [2:0] StFinish = 3'd7;

    localparam logic [1:0] ModeTx    = 2'b00;
    localparam logic [1:0] ModeRx    = 2'b01;
    localparam logic [1:0] ModeToken = 2'b11;

    logic [2:0]           state_q, state_d;
    logic [1:0]           mode_q, mode_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic                 keep_after_q, keep_after_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [PollW-1:0]     poll_q, poll_d;
    logic [2:0]           ack_q, ack_d;
    logic                 token_seen_q, token_seen_d;
    logic                 abort_pend_q, abort_pend_d;
    logic                 timeout_q, timeout_d;
    logic                 aborted_q, aborted_d;
    logic [7:0]           data_out_q, data_out_d;

    logic             polling;
    logic             poll_ff;
    logic             last_byte;
    logic             no_tx_data;
    logic [PollW-1:0] poll_inc;

    assign polling    = (mode_q == ModeToken) && !token_seen_q;
    assign poll_ff    = polling && (bus.SpiDataIn == 8'hFF);
    // A poll byte is never the final byte, even when the counter already equals Length.
    assign last_byte  = (cnt_q == len_q) && !polling;
    assign no_tx_data = (mode_q == ModeRx) || (mode_q == ModeToken);
    assign poll_inc   = poll_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        len_d        = len_q;
        keep_after_d = keep_after_q;
        cnt_d        = cnt_q;
        poll_d       = poll_q;
        ack_d        = ack_q;
        token_seen_d = token_seen_q;
        timeout_d    = timeout_q;
        aborted_d    = aborted_q;
        data_out_d   = data_out_q;
        // Abort is remembered until the next decision point so the byte in flight completes.
        abort_pend_d = abort_pend_q | (bus.Abort && (state_q != StIdle));

        case (state_q)
            StIdle: begin
                if (bus.Go) begin
                    mode_d       = bus.Mode;
                    len_d        = bus.Length;
                    keep_after_d = bus.KeepCSAfter;
                    cnt_d        = '0;
                    poll_d       = '0;
                    token_seen_d = 1'b0;
                    abort_pend_d = 1'b0;
                    timeout_d    = 1'b0;
                    aborted_d    = 1'b0;
                    state_d      = StFetch;
                end
            end
            StFetch: begin
                if (abort_pend_q) begin
                    aborted_d = 1'b1;
                    state_d   = StFinish;
                end else if (no_tx_data) begin
                    data_out_d = 8'hFF;
                    state_d    = StStart;
                end else begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                data_out_d = bus.BufRdData;
                state_d    = StStart;
            end
            StStart: begin
                ack_d   = '0;
                state_d = StAck;
            end
            StAck: begin
                // Give up waiting after 8 cycles so an idle engine cannot hang us.
                if (bus.SpiBusy || (ack_q == 3'd7)) begin
                    state_d = StXfer;
                end else begin
                    ack_d = ack_q + 1'b1;
                end
            end
            StXfer: begin
                if (!bus.SpiBusy) begin
                    state_d = StStore;
                end
            end
            StStore: begin
                if (poll_ff) begin
                    poll_d = poll_inc;
                    if (poll_inc == PollW'(TOKEN_LIMIT)) begin
                        timeout_d = 1'b1;
                        state_d   = StFinish;
                    end else if (abort_pend_q) begin
                        aborted_d = 1'b1;
                        state_d   = StFinish;
                    end else begin
                        state_d = StFetch;
                    end
                end else begin
                    if (mode_q == ModeToken) begin
                        token_seen_d = 1'b1;
                    end
                    if (abort_pend_q) begin
                        aborted_d = 1'b1;
                        state_d   = StFinish;
                    end else if (cnt_q == len_q) begin
                        state_d = StFinish;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = StFetch;
                    end
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge FastClk) begin
        if (Reset) begin
            state_q      <= StIdle;
            mode_q       <= ModeTx;
            len_q        <= '0;
            keep_after_q <= 1'b0;
            cnt_q        <= '0;
            poll_q       <= '0;
            ack_q        <= '0;
            token_seen_q <= 1'b0;
            abort_pend_q <= 1'b0;
            timeout_q    <= 1'b0;
            aborted_q    <= 1'b0;
            data_out_q   <= 8'hFF;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            len_q        <= len_d;
            keep_after_q <= keep_after_d;
            cnt_q        <= cnt_d;
            poll_q       <= poll_d;
            ack_q        <= ack_d;
            token_seen_q <= token_seen_d;
            abort_pend_q <= abort_pend_d;
            timeout_q    <= timeout_d;
            aborted_q    <= aborted_d;
            data_out_q   <= data_out_d;
        end
    end

    always_comb begin
        bus.Busy         = (state_q != StIdle) && (state_q != StFinish);
        bus.Done         = (state_q == StFinish);
        bus.TokenTimeout = timeout_q;
        bus.Aborted      = aborted_q;
        bus.BufAddr      = cnt_q;
        bus.BufWrData    = bus.SpiDataIn;
        bus.BufWe        = (state_q == StStore) && (mode_q != ModeTx) && !poll_ff;
        bus.SpiDataOut   = data_out_q;
        bus.SpiStart     = (state_q == StStart);
        bus.SpiKeepCS    = 1'b0;
        if (state_q == StStart) begin
            bus.SpiKeepCS = last_byte ? keep_after_q : 1'b1;
        end
    end
endmodule

// File: tb/tb_spi_burst_sequencer.sv
// Directed bench for spi_burst_sequencer with a small engine model and a buffer RAM model.
module tb_spi_burst_sequencer;
    localparam int unsigned LW = 9;

    logic FastClk = 1'b0;
    logic Reset;
    always #5 FastClk = ~FastClk;

    spi_burst_sequencer_if #(.LEN_WIDTH(LW)) bus ();

    spi_burst_sequencer #(
        .LEN_WIDTH  (LW),
        .TOKEN_LIMIT(4)
    ) dut (
        .FastClk(FastClk),
        .Reset  (Reset),
        .bus    (bus)
    );

    logic [7:0] tx_ram [0:15];
    logic [7:0] resp   [0:15];
    logic       eng_rst;
    logic       clr_logs;

    int         start_cnt;
    int         we_cnt;
    int         done_cnt;
    logic [7:0] start_data [0:15];
    logic       start_kcs  [0:15];
    logic [8:0] we_addr    [0:15];
    logic [7:0] we_data    [0:15];

    int         eng_phase;
    int         eng_dly;
    logic [7:0] eng_byte;

    int n_checks = 0;
    int n_errors = 0;

    // Synchronous-read buffer RAM (transmit side only; writes go to the log).
    always @(posedge FastClk) begin
        bus.BufRdData <= tx_ram[bus.BufAddr[3:0]];
    end

    always @(posedge FastClk) begin
        if (clr_logs) begin
            start_cnt <= 0;
            we_cnt    <= 0;
            done_cnt  <= 0;
        end else begin
            if (bus.SpiStart) begin
                if (start_cnt < 16) begin
                    start_data[start_cnt[3:0]] <= bus.SpiDataOut;
                    start_kcs[start_cnt[3:0]]  <= bus.SpiKeepCS;
                end
                start_cnt <= start_cnt + 1;
            end
            if (bus.BufWe) begin
                if (we_cnt < 16) begin
                    we_addr[we_cnt[3:0]] <= bus.BufAddr;
                    we_data[we_cnt[3:0]] <= bus.BufWrData;
                end
                we_cnt <= we_cnt + 1;
            end
            if (bus.Done) begin
                done_cnt <= done_cnt + 1;
            end
        end
    end

    // Engine: busy rises 2 cycles after the start cycle, stays high 4 cycles, then returns a byte.
    always @(posedge FastClk) begin
        if (eng_rst) begin
            bus.SpiBusy   <= 1'b0;
            bus.SpiDataIn <= 8'h00;
            eng_phase     <= 0;
            eng_dly       <= 0;
            eng_byte      <= 8'h00;
        end else if (bus.SpiStart) begin
            eng_phase <= 1;
            eng_dly   <= 1;
            eng_byte  <= resp[start_cnt[3:0]];
        end else if (eng_phase == 1) begin
            if (eng_dly == 0) begin
                bus.SpiBusy <= 1'b1;
                eng_phase   <= 2;
                eng_dly     <= 3;
            end else begin
                eng_dly <= eng_dly - 1;
            end
        end else if (eng_phase == 2) begin
            if (eng_dly == 0) begin
                bus.SpiBusy   <= 1'b0;
                bus.SpiDataIn <= eng_byte;
                eng_phase     <= 0;
            end else begin
                eng_dly <= eng_dly - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_burst(input logic [1:0] mode, input logic [8:0] len, input logic kca);
        @(negedge FastClk);
        clr_logs = 1'b1;
        @(negedge FastClk);
        clr_logs        = 1'b0;
        bus.Go          = 1'b1;
        bus.Mode        = mode;
        bus.Length      = len;
        bus.KeepCSAfter = kca;
        @(negedge FastClk);
        bus.Go = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge FastClk);
            if (bus.Done) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, 32'(seen), 32'd1);
        @(negedge FastClk);
    endtask

    task automatic wait_spi_busy(input string tag, input logic level, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge FastClk);
            if (bus.SpiBusy == level) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        Reset           = 1'b1;
        eng_rst         = 1'b1;
        clr_logs        = 1'b1;
        bus.Go          = 1'b0;
        bus.Abort       = 1'b0;
        bus.Mode        = 2'b00;
        bus.Length      = '0;
        bus.KeepCSAfter = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tx_ram[i] = 8'(i);
            resp[i]   = 8'hFF;
        end
        repeat (3) @(negedge FastClk);
        Reset    = 1'b0;
        eng_rst  = 1'b0;
        clr_logs = 1'b0;

        // Reset state
        check("rst_busy", 32'(bus.Busy), 0);
        check("rst_done", 32'(bus.Done), 0);
        check("rst_tto", 32'(bus.TokenTimeout), 0);
        check("rst_abt", 32'(bus.Aborted), 0);
        check("rst_we", 32'(bus.BufWe), 0);
        check("rst_start", 32'(bus.SpiStart), 0);
        check("rst_kcs", 32'(bus.SpiKeepCS), 0);
        check("rst_addr", 32'(bus.BufAddr), 0);
        check("rst_dout", 32'(bus.SpiDataOut), 32'hFF);

        // TX, Length=2
        tx_ram[0] = 8'hA5;
        tx_ram[1] = 8'h3C;
        tx_ram[2] = 8'h0F;
        start_burst(2'b00, 9'd2, 1'b0);
        check("tx_busy", 32'(bus.Busy), 1);
        wait_done("tx_done_seen", 200);
        check("tx_starts", 32'(start_cnt), 3);
        check("tx_d0", 32'(start_data[0]), 32'hA5);
        check("tx_d1", 32'(start_data[1]), 32'h3C);
        check("tx_d2", 32'(start_data[2]), 32'h0F);
        check("tx_k0", 32'(start_kcs[0]), 1);
        check("tx_k1", 32'(start_kcs[1]), 1);
        check("tx_k2", 32'(start_kcs[2]), 0);
        check("tx_we", 32'(we_cnt), 0);
        check("tx_dones", 32'(done_cnt), 1);
        check("tx_idle", 32'(bus.Busy), 0);

        // RX, Length=3
        resp[0] = 8'h11;
        resp[1] = 8'h22;
        resp[2] = 8'h33;
        resp[3] = 8'h44;
        start_burst(2'b01, 9'd3, 1'b1);
        wait_done("rx_done_seen", 300);
        check("rx_starts", 32'(start_cnt), 4);
        check("rx_we", 32'(we_cnt), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rx_dout%0d", i), 32'(start_data[i]), 32'hFF);
            check($sformatf("rx_addr%0d", i), 32'(we_addr[i]), 32'(i));
            check($sformatf("rx_wd%0d", i), 32'(we_data[i]), 32'(8'h11 * (i + 1)));
        end
        check("rx_klast", 32'(start_kcs[3]), 1);

        // Token mode, Length=1
        resp[0] = 8'hFF;
        resp[1] = 8'hFF;
        resp[2] = 8'hFE;
        resp[3] = 8'h9A;
        start_burst(2'b11, 9'd1, 1'b0);
        wait_done("tok_done_seen", 300);
        check("tok_starts", 32'(start_cnt), 4);
        check("tok_we", 32'(we_cnt), 2);
        check("tok_a0", 32'(we_addr[0]), 0);
        check("tok_d0", 32'(we_data[0]), 32'hFE);
        check("tok_a1", 32'(we_addr[1]), 1);
        check("tok_d1", 32'(we_data[1]), 32'h9A);
        check("tok_k2", 32'(start_kcs[2]), 1);
        check("tok_klast", 32'(start_kcs[3]), 0);
        check("tok_tto", 32'(bus.TokenTimeout), 0);

        // Token timeout (limit 4), engine always FF
        for (int i = 0; i < 16; i++) resp[i] = 8'hFF;
        start_burst(2'b11, 9'd3, 1'b0);
        wait_done("tto_done_seen", 300);
        check("tto_starts", 32'(start_cnt), 4);
        check("tto_we", 32'(we_cnt), 0);
        check("tto_flag", 32'(bus.TokenTimeout), 1);
        check("tto_dones", 32'(done_cnt), 1);

        // Abort during 2nd byte of an exchange, Length=5
        for (int i = 0; i < 6; i++) begin
            tx_ram[i] = 8'(8'h40 + i);
            resp[i]   = 8'(i + 1);
        end
        start_burst(2'b10, 9'd5, 1'b0);
        check("abt_tto_clr", 32'(bus.TokenTimeout), 0);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge FastClk);
                if (start_cnt == 2) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("abt_2nd_start", 32'(seen), 1);
        end
        wait_spi_busy("abt_busy_hi", 1'b1, 20);
        bus.Abort = 1'b1;
        @(negedge FastClk);
        bus.Abort = 1'b0;
        wait_done("abt_done_seen", 100);
        check("abt_starts", 32'(start_cnt), 2);
        check("abt_d1", 32'(start_data[1]), 32'h41);
        check("abt_we", 32'(we_cnt), 2);
        check("abt_wd1", 32'(we_data[1]), 32'h02);
        check("abt_flag", 32'(bus.Aborted), 1);
        check("abt_dones", 32'(done_cnt), 1);
        start_burst(2'b00, 9'd0, 1'b0);
        check("abt_clr", 32'(bus.Aborted), 0);
        wait_done("abt2_done_seen", 100);
        check("abt2_starts", 32'(start_cnt), 1);

        // Reset asserted while in XFER
        for (int i = 0; i < 4; i++) resp[i] = 8'(8'hC0 + i);
        start_burst(2'b01, 9'd3, 1'b0);
        wait_spi_busy("rst_busy_hi", 1'b1, 20);
        @(negedge FastClk);
        Reset = 1'b1;
        @(negedge FastClk);
        check("mrst_busy", 32'(bus.Busy), 0);
        check("mrst_done", 32'(bus.Done), 0);
        check("mrst_start", 32'(bus.SpiStart), 0);
        check("mrst_we", 32'(bus.BufWe), 0);
        check("mrst_addr", 32'(bus.BufAddr), 0);
        check("mrst_dout", 32'(bus.SpiDataOut), 32'hFF);
        Reset = 1'b0;
        wait_spi_busy("mrst_eng_done", 1'b0, 20);
        repeat (2) @(negedge FastClk);
        check("mrst_no_done", 32'(done_cnt), 0);
        check("mrst_starts", 32'(start_cnt), 1);
        resp[1] = 8'h5D;
        start_burst(2'b01, 9'd0, 1'b0);
        wait_done("mrst2_done_seen", 100);
        check("mrst2_starts", 32'(start_cnt), 1);
        check("mrst2_we", 32'(we_cnt), 1);
        check("mrst2_wd", 32'(we_data[0]), 32'hC0);
        check("mrst2_dones", 32'(done_cnt), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/spi_burst_sequencer.md
Name: spi_burst_sequencer

Overview:
- FastClk-domain sequencer upstream of the SPI byte engine; runs multi-byte transfers without a CPU write per byte.
- Reads transmit bytes from a buffer RAM into the engine, and writes received bytes back to the same RAM.
- Supports SD-style token polling.
- Handles only the engine's Start/DataOut/KeepCS/Busy/DataIn handshake. Register-side clock-domain crossing is out of scope.

Parameters:
- LEN_WIDTH, 9: buffer address and length width (up to 512 bytes).
- TOKEN_LIMIT, 1023: maximum 0xFF poll bytes discarded in token mode before timeout.

Ports:
- FastClk  in  1  clock.
- Reset  in  1  synchronous active-high reset.
- Go  in  1  one-cycle start pulse; ignored while Busy.
- Abort  in  1  one-cycle pulse; stops after the byte in flight.
- Mode  in  2  transfer mode: 00 TX, 01 RX, 10 exchange, 11 RX-after-token.
- Length  in  LEN_WIDTH  byte count minus 1; sampled on Go.
- KeepCSAfter  in  1  CS state after the last byte; sampled on Go.
- Busy  out  1  high from the cycle after an accepted Go until Done.
- Done  out  1  one-cycle completion pulse.
- TokenTimeout  out  1  sticky; cleared on the next accepted Go.
- Aborted  out  1  sticky; cleared on the next accepted Go.
- BufAddr  out  LEN_WIDTH  buffer RAM address.
- BufRdData  in  8  RAM read data, valid 1 cycle after BufAddr.
- BufWrData  out  8  RAM write data.
- BufWe  out  1  RAM write enable.
- SpiDataOut  out  8  byte handed to the engine.
- SpiStart  out  1  one-cycle start pulse to the engine.
- SpiKeepCS  out  1  keep-CS flag to the engine.
- SpiBusy  in  1  engine busy.
- SpiDataIn  in  8  engine received byte; valid when SpiBusy is low after a transfer.

Behaviour:
- Reset: state IDLE. Busy, Done, TokenTimeout, Aborted, BufWe, SpiStart, SpiKeepCS = 0. BufAddr = 0; SpiDataOut = 0xFF; byte counter = 0; poll counter = 0.
- Engine contract:
  - The engine latches SpiDataOut and SpiKeepCS on the SpiStart cycle.
  - SpiBusy rises 1–3 cycles after SpiStart.
  - Received data is valid from the cycle SpiBusy falls.
- States: IDLE → FETCH → LOAD → START → ACK → XFER → STORE → FETCH or FINISH → IDLE.
- IDLE:
  - Go accepted only here: latch Mode, Length, KeepCSAfter.
  - Clear counters, BufAddr, TokenTimeout and Aborted.
  - Next state FETCH.
- FETCH: drive BufAddr = byte counter. Modes 01/11 skip the RAM read and go to START with SpiDataOut = 0xFF.
- LOAD: SpiDataOut <= BufRdData.
- START:
  - SpiStart = 1 for exactly one cycle.
  - SpiKeepCS = 1, except on the final byte (counter == Length, and not a token poll), where SpiKeepCS = KeepCSAfter.
- ACK: wait for SpiBusy = 1. If it has not risen within 8 cycles, continue to XFER anyway; this avoids a deadlock on an idle engine.
- XFER: wait for SpiBusy = 0.
- STORE (all modes):
  - Mode 00: no write.
  - Modes 01/10: BufWe = 1 for one cycle, BufWrData = SpiDataIn, address = counter.
  - Mode 11, token not yet seen:
    - SpiDataIn == 0xFF: poll counter += 1, no write, counter unchanged. If poll counter reaches TOKEN_LIMIT, set TokenTimeout and go to FINISH.
    - First non-0xFF byte: mark token seen; the byte is stored at address 0 and counts as byte 0.
  - If counter == Length, go to FINISH. Otherwise increment counter and go to FETCH.
- Counter arithmetic: LEN_WIDTH-bit. Length = 2^LEN_WIDTH − 1 transfers the full buffer with no wrap, because FINISH occurs before increment.
- FINISH: Done = 1 for one cycle; Busy falls in the same cycle.
- Abort:
  - Sampled in any state other than IDLE; sets a pending flag. Ignored in IDLE.
  - The in-flight engine byte always completes, including the wait in XFER.
  - At the next STORE or FETCH decision point, skip further bytes: set Aborted, go to FINISH.
  - No further SpiStart is issued.
  - The byte received during abort is still stored (modes 01/10/11-after-token).
- Go while Busy: ignored, no effect. Go and Abort in the same IDLE cycle: Go accepted, Abort ignored.
- Reset mid-transfer: returns to IDLE immediately; no Done. The engine byte in flight finishes on its own.

Test Plan:
- TX, Length=2, RAM[0..2] = A5,3C,0F, KeepCSAfter=0:
  - Three SpiStart pulses with SpiDataOut A5,3C,0F.
  - SpiKeepCS = 1,1,0.
  - No BufWe; one Done.
- RX, Length=3, engine returns 11,22,33,44:
  - SpiDataOut = FF each byte.
  - BufWe writes 11,22,33,44 to addresses 0..3.
  - Done after the 4th SpiBusy fall.
- Token mode, Length=1, engine returns FF,FF,FE,9A:
  - 4 SpiStarts; RAM[0]=FE, RAM[1]=9A.
  - TokenTimeout = 0; final SpiKeepCS = KeepCSAfter.
- Token timeout with TOKEN_LIMIT=4, engine always FF:
  - Exactly 4 SpiStarts, no BufWe.
  - TokenTimeout = 1; Done pulse.
- Abort during the 2nd byte of an exchange with Length=5:
  - Byte 2 completes and is stored.
  - No 3rd SpiStart; Aborted = 1; Done pulse.
  - Next Go clears Aborted.
- Reset asserted in XFER:
  - The next cycle shows all outputs at reset values and IDLE.
  - A subsequent Go with Length=0 transfers exactly 1 byte.
